// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: one-hot row strobe, two-flop column synchronizer,
// press/release debounce and a one-cycle key event with a held key code.
module keypad_scanner #(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic       FPGA_CLK,
  input  logic       FPGA_RST_BTN,
  input  logic [2:0] KEYPAD_COL,
  output logic [3:0] KEYPAD_ROW,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    row_q, row_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    col_lat_q, col_lat_d;
  logic          valid_q, valid_d;
  logic [3:0]    code_q, code_d;
  logic          held_q, held_d;
  logic [2:0]    col_meta_q, col_s_q;

  // Row one-hot [3]=row0 and column one-hot [2]=col0 to the key code.
  function automatic logic [3:0] decode_key(input logic [3:0] row, input logic [2:0] col);
    logic [3:0] base;
    logic [3:0] idx;
    idx = col[2] ? 4'd0 : (col[1] ? 4'd1 : 4'd2);
    case (row)
      4'b1000: base = 4'd1;
      4'b0100: base = 4'd4;
      4'b0010: base = 4'd7;
      default: base = 4'd0;
    endcase
    if (row == 4'b0001) begin
      decode_key = col[2] ? 4'hE : (col[1] ? 4'h0 : 4'hF);
    end else begin
      decode_key = base + idx;
    end
  endfunction

  // NOTE: every flop uses non-blocking assignment so all registers update
  // together on the edge; blocking here would let col_s_q see the new meta value.
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST_BTN) begin
    if (!FPGA_RST_BTN) begin
      col_meta_q <= 3'b000;
      col_s_q    <= 3'b000;
    end else begin
      col_meta_q <= KEYPAD_COL;
      col_s_q    <= col_meta_q;
    end
  end

  always_ff @(posedge FPGA_CLK or negedge FPGA_RST_BTN) begin
    if (!FPGA_RST_BTN) begin
      state_q   <= ST_SCAN;
      row_q     <= 4'b1000;
      dwell_q   <= '0;
      cnt_q     <= '0;
      col_lat_q <= 3'b000;
      valid_q   <= 1'b0;
      code_q    <= 4'h0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      col_lat_q <= col_lat_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      held_q    <= held_d;
    end
  end

  // NOTE: every signal gets its default before the case, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    col_lat_d = col_lat_q;
    valid_d   = 1'b0;
    code_d    = code_q;
    held_d    = held_q;

    case (state_q)
      ST_SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if ($onehot(col_s_q)) begin
            col_lat_d = col_s_q;
            cnt_d     = '0;
            state_d   = ST_DEBOUNCE;
          end else begin
            row_d = {row_q[0], row_q[3:1]};
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end

      ST_DEBOUNCE: begin
        if (col_s_q == col_lat_q) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_PRESSED;
            valid_d = 1'b1;
            code_d  = decode_key(row_q, col_lat_q);
            held_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          // Bounce: rescan the same row from a fresh dwell.
          state_d = ST_SCAN;
          dwell_d = '0;
        end
      end

      ST_PRESSED: begin
        if (col_s_q == 3'b000) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end
      end

      ST_RELEASE: begin
        if (col_s_q != 3'b000) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_SCAN;
          held_d  = 1'b0;
          row_d   = {row_q[0], row_q[3:1]};
          dwell_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = ST_SCAN;
    endcase
  end

  assign KEYPAD_ROW = row_q;
  assign key_valid  = valid_q;
  assign key_code   = code_q;
  assign key_held   = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: reset, row rotation, press/hold/release,
// bounce rejection, row-3 keys, multi-column rejection and mid-debounce reset.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] col = 3'b000;
  logic [3:0] row;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  int compared   = 0;
  int mismatched = 0;
  int pulses     = 0;
  int p0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYC(4)) dut (
    .FPGA_CLK    (clk),
    .FPGA_RST_BTN(rst_n),
    .KEYPAD_COL  (col),
    .KEYPAD_ROW  (row),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_held    (key_held)
  );

  always #5 clk = ~clk;

  // Counts the registered pulse value present just before each rising edge.
  always @(posedge clk) if (key_valid === 1'b1) pulses++;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_row(input logic [3:0] target, input string tag);
    for (int i = 0; i < 100 && row !== target; i++) @(negedge clk);
    chk(tag, row, target);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 40 && key_valid !== 1'b1; i++) @(negedge clk);
    chk(tag, {3'b000, key_valid}, 4'h1);
  endtask

  task automatic wait_held_low(input string tag);
    for (int i = 0; i < 60 && key_held !== 1'b0; i++) @(negedge clk);
    chk(tag, {3'b000, key_held}, 4'h0);
  endtask

  task automatic press_key(input logic [3:0] r, input logic [2:0] c,
                           input logic [3:0] exp_code, input string tag);
    p0 = pulses;
    wait_row(r, {tag, "_row"});
    col = c;
    wait_valid({tag, "_valid"});
    chk({tag, "_code"}, key_code, exp_code);
    chk({tag, "_held_at_valid"}, {3'b000, key_held}, 4'h1);
    repeat (20) @(negedge clk);
    chk({tag, "_held_mid"}, {3'b000, key_held}, 4'h1);
    chk({tag, "_row_frozen"}, row, r);
    col = 3'b000;
    wait_held_low({tag, "_release"});
    chk({tag, "_row_next"}, row, {r[0], r[3:1]});
    repeat (2) @(negedge clk);
    chk({tag, "_one_pulse"}, 4'(pulses - p0), 4'h1);
    chk({tag, "_code_kept"}, key_code, exp_code);
  endtask

  initial begin
    // 1: reset values, then rotation every 4 cycles
    repeat (5) @(negedge clk);
    chk("rst_row", row, 4'b1000);
    chk("rst_valid", {3'b000, key_valid}, 4'h0);
    chk("rst_code", key_code, 4'h0);
    chk("rst_held", {3'b000, key_held}, 4'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rot_dwell", row, 4'b1000);
    @(negedge clk); chk("rot_0100", row, 4'b0100);
    repeat (4) @(negedge clk); chk("rot_0010", row, 4'b0010);
    repeat (4) @(negedge clk); chk("rot_0001", row, 4'b0001);
    repeat (4) @(negedge clk); chk("rot_1000", row, 4'b1000);

    // 2: press '5'
    press_key(4'b0100, 3'b010, 4'h5, "key5");

    // 3: long hold of '5'
    wait_row(4'b1000, "long_sync0");
    wait_row(4'b0100, "long_sync1");
    p0 = pulses;
    col = 3'b010;
    repeat (500) @(negedge clk);
    chk("long_one_pulse", 4'(pulses - p0), 4'h1);
    chk("long_row", row, 4'b0100);
    chk("long_held", {3'b000, key_held}, 4'h1);
    col = 3'b000;
    repeat (4) @(negedge clk);
    chk("long_rel_row", row, 4'b0100);
    chk("long_rel_held", {3'b000, key_held}, 4'h1);
    wait_row(4'b0010, "long_next_row");
    chk("long_held_low", {3'b000, key_held}, 4'h0);

    // 4: bounce shorter than the debounce window
    wait_row(4'b1000, "bounce_sync0");
    wait_row(4'b0100, "bounce_sync1");
    p0 = pulses;
    @(negedge clk);
    col = 3'b010;
    repeat (2) @(negedge clk);
    col = 3'b000;
    repeat (3) @(negedge clk);
    chk("bounce_same_row", row, 4'b0100);
    wait_row(4'b0010, "bounce_resume");
    chk("bounce_no_pulse", 4'(pulses - p0), 4'h0);
    chk("bounce_code", key_code, 4'h5);
    chk("bounce_held", {3'b000, key_held}, 4'h0);

    // 5: row-3 keys
    press_key(4'b0001, 3'b100, 4'hE, "key_star");
    press_key(4'b0001, 3'b010, 4'h0, "key_zero");
    press_key(4'b0001, 3'b001, 4'hF, "key_hash");

    // 6a: two columns at once are ignored
    wait_row(4'b0001, "multi_sync0");
    wait_row(4'b1000, "multi_sync1");
    p0 = pulses;
    col = 3'b110;
    wait_row(4'b0100, "multi_rot1");
    wait_row(4'b0010, "multi_rot2");
    col = 3'b000;
    chk("multi_no_pulse", 4'(pulses - p0), 4'h0);
    chk("multi_held", {3'b000, key_held}, 4'h0);
    chk("multi_code", key_code, 4'hF);

    // 6b: reset during debounce of '1'
    wait_row(4'b0001, "rstmid_sync0");
    wait_row(4'b1000, "rstmid_sync1");
    p0 = pulses;
    col = 3'b100;
    repeat (6) @(negedge clk);
    chk("rstmid_pre_valid", {3'b000, key_valid}, 4'h0);
    rst_n = 1'b0;
    col = 3'b000;
    #1;
    chk("rstmid_row", row, 4'b1000);
    chk("rstmid_valid", {3'b000, key_valid}, 4'h0);
    chk("rstmid_code", key_code, 4'h0);
    chk("rstmid_held", {3'b000, key_held}, 4'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("rstmid_no_pulse", 4'(pulses - p0), 4'h0);
    chk("rstmid_code_after", key_code, 4'h0);
    chk("rstmid_held_after", {3'b000, key_held}, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
